// File: rtl/joy_scan.sv
// Multi-port Mega Drive pad scanner: one shared select sequencer drives every
// port, and a per-port lane samples, classifies and publishes the button word.

module joy_scan_lane #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  pins,      // {d9, d6, d4, d3, d2, d1}
  input  logic        smp_h1,
  input  logic        smp_l1,
  input  logic        smp_l3,
  input  logic        smp_h4,
  input  logic        commit,
  output logic [11:0] joy,
  output logic        present,
  output logic        six
);
  // X, Y, Z and Mode only exist on a 6-button pad
  localparam logic [11:0] SIX_ONLY = 12'hE04;

  logic [5:0]  sync1, sync2, lvl;
  logic [11:0] sh_joy;
  logic        sh_pres, sh_six;

  always_ff @(posedge clock) begin
    sync1 <= pins;
    sync2 <= sync1;
  end

  // button storage is active-high; detection below always tests raw lows
  assign lvl = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sh_joy  <= '0;
      sh_pres <= 1'b0;
      sh_six  <= 1'b0;
      joy     <= '0;
      present <= 1'b0;
      six     <= 1'b0;
    end else begin
      if (smp_h1) begin
        sh_joy[4] <= lvl[0];
        sh_joy[5] <= lvl[1];
        sh_joy[6] <= lvl[2];
        sh_joy[7] <= lvl[3];
        sh_joy[0] <= lvl[4];
        sh_joy[8] <= lvl[5];
      end
      if (smp_l1) begin
        sh_joy[1] <= lvl[4];
        sh_joy[3] <= lvl[5];
        sh_pres   <= ~sync2[2] & ~sync2[3];
      end
      if (smp_l3)
        sh_six <= ~|sync2[3:0];
      if (smp_h4 && sh_six) begin
        sh_joy[9]  <= lvl[0];
        sh_joy[10] <= lvl[1];
        sh_joy[11] <= lvl[2];
        sh_joy[2]  <= lvl[3];
      end
      if (commit) begin
        present <= sh_pres;
        six     <= sh_pres & sh_six;
        if (!sh_pres)
          joy <= '0;
        else if (!sh_six)
          joy <= sh_joy & ~SIX_ONLY;
        else
          joy <= sh_joy;
      end
    end
  end
endmodule

module joy_scan #(
  parameter int STEP_TICKS  = 500,
  parameter int FRAME_STEPS = 16,
  parameter int PORTS       = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PORTS-1:0]      pin_d1,
  input  logic [PORTS-1:0]      pin_d2,
  input  logic [PORTS-1:0]      pin_d3,
  input  logic [PORTS-1:0]      pin_d4,
  input  logic [PORTS-1:0]      pin_d6,
  input  logic [PORTS-1:0]      pin_d9,
  output logic [PORTS-1:0]      pin_d7,
  output logic [12*PORTS-1:0]   joy,
  output logic [PORTS-1:0]      present,
  output logic [PORTS-1:0]      six,
  output logic                  valid
);
  localparam int              TW     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(STEP_TICKS - 1);
  localparam logic [3:0]      S_LAST = 4'(FRAME_STEPS - 1);

  localparam logic [3:0] ST_H1     = 4'd1;
  localparam logic [3:0] ST_L1     = 4'd2;
  localparam logic [3:0] ST_FALL2  = 4'd3;
  localparam logic [3:0] ST_FALL3  = 4'd5;
  localparam logic [3:0] ST_L3     = 4'd6;
  localparam logic [3:0] ST_H4     = 4'd7;
  localparam logic [3:0] ST_COMMIT = 4'd8;

  logic [TW-1:0] t;
  logic [3:0]    step;
  logic          tick, sel;
  logic          smp_h1, smp_l1, smp_l3, smp_h4, commit;

  logic [PORTS-1:0][5:0]  lane_pins;
  logic [PORTS-1:0][11:0] lane_joy;

  assign tick = (t == T_LAST);

  // each step's action happens on its last tick, so samples see the phase
  // that is ending before select moves
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      t     <= '0;
      step  <= '0;
      sel   <= 1'b1;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick) begin
        t    <= '0;
        step <= (step == S_LAST) ? 4'd0 : step + 4'd1;
        case (step)
          ST_H1, ST_FALL2, ST_FALL3, ST_H4: sel <= 1'b0;
          ST_COMMIT: begin
            sel   <= 1'b1;
            valid <= 1'b1;
          end
          default: sel <= 1'b1;
        endcase
      end else begin
        t <= t + TW'(1);
      end
    end
  end

  assign smp_h1 = tick && (step == ST_H1);
  assign smp_l1 = tick && (step == ST_L1);
  assign smp_l3 = tick && (step == ST_L3);
  assign smp_h4 = tick && (step == ST_H4);
  assign commit = tick && (step == ST_COMMIT);

  assign pin_d7 = {PORTS{sel}};
  assign joy    = lane_joy;

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    assign lane_pins[p] = {pin_d9[p], pin_d6[p], pin_d4[p],
                           pin_d3[p], pin_d2[p], pin_d1[p]};

    joy_scan_lane #(.ACTIVE_LOW(ACTIVE_LOW)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .pins    (lane_pins[p]),
      .smp_h1  (smp_h1),
      .smp_l1  (smp_l1),
      .smp_l3  (smp_l3),
      .smp_h4  (smp_h4),
      .commit  (commit),
      .joy     (lane_joy[p]),
      .present (present[p]),
      .six     (six[p])
    );
  end
endmodule

// File: doc/joy_scan.md
# joy_scan

Parametrised Sega Mega Drive gamepad scanner for one or more DB-9 ports. It drives each port's select line through a fixed 9-step sequence and samples the pad in every phase. It detects per port whether a pad is present and whether it is a 3- or 6-button pad, and publishes a 12-bit active-high button word per port. All words update atomically once per frame, with a one-cycle valid strobe. It sits between the board DB-9 pins and the console input registers, and replaces the single-port, raw-level pad reader.

## Interface
- `STEP_TICKS`, default 500: clocks per step; 20 µs at 25 MHz.
- `FRAME_STEPS`, default 16: steps per frame, legal range 9–16. Steps 9..FRAME_STEPS-1 are idle, with select held high.
- `PORTS`, default 2: number of independent pad ports.
- `ACTIVE_LOW`, default 1: 1 means the pins read 0 when a button is pressed, and the outputs are inverted so that pressed reads 1.

Ports:
- `clock` in 1: system clock, 25 MHz.
- `reset_n` in 1: synchronous reset, active low.
- `pin_d1`, `pin_d2`, `pin_d3`, `pin_d4`, `pin_d6`, `pin_d9` in [PORTS-1:0]: pad data pins; bit p belongs to port p.
- `pin_d7` out [PORTS-1:0]: select line per port. All bits carry the same value.
- `joy` out [12*PORTS-1:0]: button words; port p occupies bits [12p+11:12p].
- `present` out [PORTS-1:0]: a pad was detected on the port in the last frame.
- `six` out [PORTS-1:0]: the detected pad is a 6-button pad.
- `valid` out 1: one-cycle pulse; `joy`, `present` and `six` updated on this cycle.

Button word layout, from bit 11 down to bit 0: X, Y, Z, C, Right, Left, Down, Up, Start, Mode, A, B.

## Operation
- Input synchronisation: each data pin passes through a 2-flop synchroniser. All sampling uses the synchronised value. "Low" below means the raw pin level is 0.
- Counters:
  - `t` runs 0..STEP_TICKS-1.
  - `step` runs 0..FRAME_STEPS-1 and wraps to 0.
  - When t==STEP_TICKS-1, that clock performs the action of the current `step`, sets t to 0 and advances `step`.
- Step actions. A sample captures the phase that has just ended, before the select line changes.
  - 0: select := 1.
  - 1: sample phase H1 into a shadow word: Up=d1, Down=d2, Left=d3, Right=d4, B=d6, C=d9. Then select := 0.
  - 2: sample phase L1 into the shadow: A=d6, Start=d9. Presence is set when d3 and d4 are both low. Then select := 1.
  - 3 and 5: select := 0.
  - 4: select := 1.
  - 6: sample phase L3. The shadow six flag is set when d1..d4 are all low. Then select := 1.
  - 7: sample phase H4: Z=d1, Y=d2, X=d3, Mode=d4, stored only if the shadow six flag is set. Then select := 0.
  - 8: select := 1. Commit all shadows to the outputs and pulse `valid`.
  - 9 and above: idle, select stays 1, no sampling.
- Commit rules, applied per port:
  - Shadow presence = 0: `joy` word = 0, `six` = 0, `present` = 0.
  - Present but not six: X, Y, Z and Mode are forced to 0.
  - ACTIVE_LOW=1: sampled pin levels are inverted before storage. Presence and six detection always test raw-low levels, regardless of ACTIVE_LOW.
- Ports are scanned in parallel on identical timing; there is no per-port state machine.
- Outputs hold their values between commits.

## Timing
- Reset values:
  - t = 0, step = 0.
  - `pin_d7` = all ones.
  - `joy`, `present`, `six` = 0; `valid` = 0.
  - All shadow registers = 0.
- `valid` is high exactly one clock: the clock after step 8's action clock, when the new outputs first appear.
- Frame period is FRAME_STEPS × STEP_TICKS clocks (16 × 500 = 8000 clocks, i.e. 320 µs at default).
- The first `valid` after reset arrives 9 × STEP_TICKS clocks after reset release.
- Pin-to-sample latency is 2 clocks (the synchroniser). Pins must be stable for at least 3 clocks before a sample edge.
- Reset asserted mid-frame aborts the frame immediately:
  - Shadows are cleared and nothing is committed.
  - `pin_d7` returns high on the next clock.
  - The sequence restarts at step 0.
- With FRAME_STEPS=9 there is no idle gap: step 8 wraps directly to step 0.

## Test plan
- Reset, then no pad (all pins high): first `valid` at clock 9×STEP_TICKS+1. `present`=0, `six`=0, `joy`=0. `pin_d7` sequence over steps 0–8 is 1,0,1,0,1,0,1,0,1.
- 3-button pad model with Up and Start pressed, using STEP_TICKS=4: `joy`=12'h018, `present`=1, `six`=0. Any X/Y/Z/Mode pins held low during H4 must still yield bits 11, 10, 9 and 2 = 0.
- 6-button pad model (drives d1..d4 low in L3) with X, Z, B and Mode pressed: `joy`=12'hA05, `six`=1, `present`=1.
- PORTS=2, port 0 with a 6-button pad pressing A, port 1 unconnected: `joy[11:0]`=12'h002, `joy[23:12]`=0, `present`=2'b01, `six`=2'b01.
- Assert `reset_n` low during step 5, then release: `pin_d7` is high one clock after reset is applied. Outputs stay 0 until a full fresh frame completes. No `valid` pulse occurs from the aborted frame.
- Button changes while t is mid-step during step 3: the outputs change only at the next `valid` pulse, and `valid` spacing is exactly FRAME_STEPS×STEP_TICKS clocks.
